// File: rtl/reg_file_pkg.sv
// Shared datapath definitions for the register file: default sizes and the
// clear/write priority encoding used by the storage decoder.
package reg_file_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 4;

  typedef enum logic [1:0] {
    WOP_IDLE  = 2'd0,
    WOP_WRITE = 2'd1,
    WOP_CLEAR = 2'd2
  } wr_op_e;

  // Clear always wins; a write aimed at a hard-wired zero entry is dropped.
  function automatic wr_op_e decode_wr_op(input logic clr, input logic wr_en,
                                          input logic wr_zero);
    if (clr)               return WOP_CLEAR;
    if (wr_en && !wr_zero) return WOP_WRITE;
    return WOP_IDLE;
  endfunction

endpackage

// File: rtl/reg_file_rdport.sv
// One registered read port: enable-gated output register with clear,
// zero-register and write-bypass selection in front of it.
module reg_file_rdport
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] entry_data,
  input  logic              wr_hit,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  logic              rd_zero;
  logic [DATA_W-1:0] rd_next;

  assign rd_zero = (ZERO_REG != 0) && (rd_addr == '0);

  always_comb begin
    rd_next = entry_data;
    if (clr || rd_zero)                rd_next = '0;
    else if ((BYPASS != 0) && wr_hit)  rd_next = wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= rd_next;
  end

endmodule

// File: rtl/reg_file.sv
// General-purpose register file: DEPTH x DATA_W storage, one write port,
// two registered read ports, synchronous clear and per-entry written flags.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int   DATA_W   = DATA_W_DEF,
  parameter int   DEPTH    = DEPTH_DEF,
  parameter int   ZERO_REG = 0,
  parameter int   BYPASS   = 1,
  localparam int  ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en_a,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [DATA_W-1:0] rd_data_a,
  input  logic              rd_en_b,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DEPTH-1:0]  written
);

  localparam int NUM_PORTS = 2;

  logic [DEPTH-1:0][DATA_W-1:0]     mem;
  wr_op_e                           op;
  logic                             wr_zero;

  logic [NUM_PORTS-1:0]             rd_en;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rd_data;
  logic [NUM_PORTS-1:0][DATA_W-1:0] entry_rd;
  logic [NUM_PORTS-1:0]             wr_hit;

  assign wr_zero = (ZERO_REG != 0) && (wr_addr == '0);
  assign op      = decode_wr_op(clr, wr_en, wr_zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem     <= '0;
      written <= '0;
    end else begin
      case (op)
        WOP_CLEAR: begin
          mem     <= '0;
          written <= '0;
        end
        WOP_WRITE: begin
          mem[wr_addr]     <= wr_data;
          written[wr_addr] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rd_en   = {rd_en_b, rd_en_a};
  assign rd_addr = {rd_addr_b, rd_addr_a};

  genvar p;
  generate
    for (p = 0; p < NUM_PORTS; p++) begin : g_port
      assign entry_rd[p] = mem[rd_addr[p]];
      // Only a write that will actually land counts as a bypass hit.
      assign wr_hit[p]   = (op == WOP_WRITE) && (wr_addr == rd_addr[p]);

      reg_file_rdport #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .BYPASS  (BYPASS),
        .ZERO_REG(ZERO_REG)
      ) u_rdport (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .rd_en     (rd_en[p]),
        .rd_addr   (rd_addr[p]),
        .entry_data(entry_rd[p]),
        .wr_hit    (wr_hit[p]),
        .wr_data   (wr_data),
        .rd_data   (rd_data[p])
      );
    end
  endgenerate

  assign rd_data_a = rd_data[0];
  assign rd_data_b = rd_data[1];

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench: two register files (bypass/no-zero and no-bypass/zero-reg)
// share one directed stimulus stream; a monitor checks each registered read.
module tb_reg_file;
  import reg_file_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, clr, wr_en, rd_en_a, rd_en_b;
  logic [1:0]  wr_addr, rd_addr_a, rd_addr_b;
  logic [15:0] wr_data;
  logic [15:0] rd_a0, rd_b0, rd_a1, rd_b1;
  logic [3:0]  wr0, wr1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] e0;
    logic [15:0] e1;
    string       tag;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  logic vld_a, vld_b;

  always #5 clk = ~clk;

  reg_file #(.DATA_W(16), .DEPTH(4), .ZERO_REG(0), .BYPASS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
    .rd_data_a(rd_a0), .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
    .rd_data_b(rd_b0), .written(wr0)
  );

  reg_file #(.DATA_W(16), .DEPTH(4), .ZERO_REG(1), .BYPASS(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a),
    .rd_data_a(rd_a1), .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
    .rd_data_b(rd_b1), .written(wr1)
  );

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_a(input logic [15:0] e0, input logic [15:0] e1, input string tag);
    exp_t e;
    e.e0 = e0; e.e1 = e1; e.tag = tag;
    qa.push_back(e);
  endtask

  task automatic push_b(input logic [15:0] e0, input logic [15:0] e1, input string tag);
    exp_t e;
    e.e0 = e0; e.e1 = e1; e.tag = tag;
    qb.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
    clr = 1'b0; wr_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic rda(input logic [1:0] a);
    rd_en_a = 1'b1; rd_addr_a = a;
  endtask

  task automatic rdb(input logic [1:0] a);
    rd_en_b = 1'b1; rd_addr_b = a;
  endtask

  // A read issued at edge N is presented after edge N.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_a <= 1'b0;
      vld_b <= 1'b0;
    end else begin
      vld_a <= rd_en_a;
      vld_b <= rd_en_b;
    end
  end

  always @(negedge clk) begin
    if (vld_a) begin
      if (qa.size() == 0) chk("port_a_unexpected", rd_a0, 16'hxxxx);
      else begin
        ea = qa.pop_front();
        chk({ea.tag, "_a_dut0"}, rd_a0, ea.e0);
        chk({ea.tag, "_a_dut1"}, rd_a1, ea.e1);
      end
    end
    if (vld_b) begin
      if (qb.size() == 0) chk("port_b_unexpected", rd_b0, 16'hxxxx);
      else begin
        eb = qb.pop_front();
        chk({eb.tag, "_b_dut0"}, rd_b0, eb.e0);
        chk({eb.tag, "_b_dut1"}, rd_b1, eb.e1);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
    wr_addr = '0; wr_data = '0; rd_addr_a = '0; rd_addr_b = '0;
    #1;
    chk("reset_rd_a0", rd_a0, 16'h0000);
    chk("reset_rd_b1", rd_b1, 16'h0000);
    chk("reset_written0", {12'h0, wr0}, 16'h0000);
    chk("reset_written1", {12'h0, wr1}, 16'h0000);
    #11 rst_n = 1'b1;

    step(); wr(2'd2, 16'hBEEF);
    step(); chk("written_after_beef0", {12'h0, wr0}, 16'h0004);
            chk("written_after_beef1", {12'h0, wr1}, 16'h0004);
            rda(2'd2); push_a(16'hBEEF, 16'hBEEF, "wr_then_rd");
    step(); wr(2'd1, 16'h0005);
    step(); wr(2'd1, 16'h1234); rdb(2'd1); push_b(16'h1234, 16'h0005, "bypass");
    step(); rdb(2'd1); push_b(16'h1234, 16'h1234, "reread");
    step(); wr(2'd0, 16'hFFFF);
    step(); chk("written_zero0", {12'h0, wr0}, 16'h0007);
            chk("written_zero1", {12'h0, wr1}, 16'h0006);
            rda(2'd0); rdb(2'd0);
            push_a(16'hFFFF, 16'h0000, "zero_reg");
            push_b(16'hFFFF, 16'h0000, "zero_reg");
    step(); wr(2'd3, 16'h1111);
    step(); wr(2'd2, 16'h2222);
    step(); wr(2'd0, 16'h3333);
    step(); chk("hold_a_dut0", rd_a0, 16'hFFFF);
            chk("hold_a_dut1", rd_a1, 16'h0000);
            rda(2'd2); rdb(2'd2);
            push_a(16'h2222, 16'h2222, "dual_read");
            push_b(16'h2222, 16'h2222, "dual_read");
    for (int i = 0; i < 4; i++) begin
      step(); wr(i[1:0], 16'hAAAA);
    end
    step(); clr = 1'b1; wr(2'd3, 16'h5555); rda(2'd3); rdb(2'd3);
            push_a(16'h0000, 16'h0000, "clr_read");
            push_b(16'h0000, 16'h0000, "clr_read");
    step(); chk("written_clr0", {12'h0, wr0}, 16'h0000);
            chk("written_clr1", {12'h0, wr1}, 16'h0000);
            rda(2'd3); rdb(2'd1);
            push_a(16'h0000, 16'h0000, "after_clr");
            push_b(16'h0000, 16'h0000, "after_clr");
    step(); wr(2'd3, 16'h5555);
    step(); rda(2'd3); rdb(2'd3);
            push_a(16'h5555, 16'h5555, "pre_reset");
            push_b(16'h5555, 16'h5555, "pre_reset");
    step();
    @(posedge clk); #1;
    chk("queue_a_drained", 16'(qa.size()), 16'h0000);
    chk("queue_b_drained", 16'(qb.size()), 16'h0000);

    // Mid-cycle asynchronous reset must clear outputs without a clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_a0", rd_a0, 16'h0000);
    chk("async_rst_b0", rd_b0, 16'h0000);
    chk("async_rst_a1", rd_a1, 16'h0000);
    chk("async_rst_b1", rd_b1, 16'h0000);
    chk("async_rst_written0", {12'h0, wr0}, 16'h0000);
    step(); step();
    rst_n = 1'b1;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
